wb_kbd_fifo_periph: RTL and testbench
=====================================

Name: wb_kbd_fifo_periph

Overview:
Wishbone-slave keyboard peripheral that buffers scan codes from the PS/2 serial-to-parallel receiver in a parametrised FIFO. It replaces the single-register "code + flag" scheme. The CPU reads the status word, then pops codes with a data read. Sits on the CPU MMIO bus beside the other 32-bit register peripherals and drives one level interrupt to the CPU.

Parameters:
DATA_W, 8, scan-code width in bits (1..24)
DEPTH, 16, FIFO entries; power of two, 2..256
clk_freq_hz, 0, system clock frequency; informational only, no logic depends on it

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_kbd_data  in  DATA_W  scan code from receiver
i_kbd_valid  in  1  one-cycle strobe, i_kbd_data valid
i_wb_adr  in  6  byte address; [4:2] selects the register
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte selects; all writes are treated as full-word writes
i_wb_we  in  1  write enable
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
o_wb_rdt  out  32  read data, registered
o_wb_ack  out  1  acknowledge
o_irq  out  1  level interrupt, registered

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous, active-high.
- Reset values:
  - o_wb_ack=0, o_wb_rdt=0, o_irq=0
  - FIFO empty, count=0, overflow=0
  - CTRL=0x1 (capture on, irq off), SCRATCH=0
- Bus handshake:
  - o_wb_ack <= cyc & stb & !o_wb_ack. This gives exactly one ack cycle, one cycle after the request, and ack never stays high two cycles in a row.
  - Register write/read side effects occur only in the accepting cycle (cyc & stb & !ack).
  - o_wb_rdt is valid in the same cycle as o_wb_ack.
- Register map (byte offsets):
  - 0x00 DATA (RO):
    - Reading returns the FIFO head zero-extended in [DATA_W-1:0] and pops one entry.
    - Read when empty returns 0; no pop, no error.
    - Writes are ignored.
  - 0x04 STATUS:
    - Read: bit0 not_empty, bit1 full, bit2 overflow (sticky), bits [16:8] count (0..DEPTH); all other bits 0.
    - Write: bit2 = 1 clears overflow (write-1-to-clear); all other bits ignored.
  - 0x08 CTRL (RW): bit0 capture_en, bit1 irq_en, bit2 flush.
    - flush is self-clearing: it empties the FIFO next cycle and always reads back 0.
  - 0x0C SCRATCH (RW, 32 bits): no side effects.
  - 0x10..0x1C: reads return 0, writes are ignored; ack is still given.
- Push rules:
  - A push occurs when i_kbd_valid & capture_en & !full.
  - i_kbd_valid & capture_en & full: the code is dropped, overflow <= 1, FIFO contents unchanged.
  - i_kbd_valid with capture_en=0: ignored; overflow is not set.
- Simultaneous events:
  - Push and pop in the same cycle:
    - both take effect and count is unchanged;
    - when empty, the pop is invalid (reads 0) and only the push occurs;
    - when full, the pop frees a slot and the push is accepted with no overflow.
  - Flush write coinciding with a push: flush wins; FIFO empty, count=0.
  - Overflow set and W1C clear in the same cycle: set wins.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits. full = (count==DEPTH).
- Interrupt: o_irq <= irq_en & (not_empty | overflow). It is registered, so it follows state with one-cycle latency.
- Reset mid-transaction:
  - all state returns to reset values on the next edge and any in-flight ack is cancelled;
  - the FIFO storage array need not be cleared.

Optional Feature:
KBD_TIMESTAMP_EN
- Defined:
  - adds a free-running 32-bit cycle counter (reset 0, wraps at 2^32);
  - each accepted push stores the counter value alongside the code;
  - a DATA pop latches that entry's timestamp into register 0x10 (RO, reset 0); an empty pop leaves 0x10 unchanged.
- Undefined:
  - no counter and no timestamp storage;
  - 0x10 reads 0 like the other reserved offsets.

Test Plan:
- Reset, then read STATUS -> 0x00000000; read CTRL -> 0x1; read DATA -> 0; each ack is exactly one cycle wide, one cycle after stb.
- Push 0x1C, 0x32, 0x21; read STATUS -> 0x00000301; three DATA reads -> 0x1C, 0x32, 0x21 in order; final STATUS -> 0x0.
- DEPTH=16: push 17 codes 0x01..0x11 -> STATUS 0x00001007 (count 16, full, overflow, not_empty); first pop returns 0x01; write STATUS 0x4 -> overflow cleared, count 15.
- Hold 16 entries and issue a DATA read in the same cycle as push 0xAA -> count stays 16, no overflow; 0xAA is the last of the 16 entries popped.
- CTRL=0x3 with one push -> o_irq rises 2 cycles after i_kbd_valid; pop -> o_irq falls; write CTRL 0x7 with 5 entries -> count 0, CTRL reads 0x3.
- Assert i_rst for 1 cycle in the middle of a read cycle and with 4 entries queued -> next cycle ack=0, rdt=0, STATUS 0x0, CTRL 0x1.

Source files
------------

// File: rtl/wb_kbd_fifo_periph_if.sv
// Wishbone classic bus between the CPU MMIO fabric and the keyboard FIFO peripheral.
// Signal names keep the slave's point of view (i_ = into the peripheral).
interface wb_kbd_fifo_periph_if;
    logic [5:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/wb_kbd_fifo_periph.sv
// Wishbone keyboard peripheral: scan codes are queued in a FIFO and popped by DATA reads.
// Optional KBD_TIMESTAMP_EN stores a cycle-count timestamp per code, readable at 0x10 after a pop.
module wb_kbd_fifo_periph #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int clk_freq_hz = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_W-1:0]     i_kbd_data,
    input  logic                  i_kbd_valid,
    wb_kbd_fifo_periph_if.slave   wb,
    output logic                  o_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, cap_en_q, cap_en_d, irq_en_q, irq_en_d;
    logic              flush_q, flush_d, ack_q, ack_d, irq_q, irq_d;
    logic [31:0]       scratch_q, scratch_d, rdt_q, rdt_d;

    logic              accept, rd_acc, wr_acc, not_empty, full, pop, push, drop;
    logic [2:0]        reg_sel;
    logic [31:0]       status_word;

`ifdef KBD_TIMESTAMP_EN
    logic [31:0]       ts_cnt_q;
    logic [31:0]       ts_mem_q [DEPTH];
    logic [31:0]       ts_q, ts_d;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, wb.i_wb_sel, wb.i_wb_adr[5], wb.i_wb_adr[1:0], clk_freq_hz == 0};

    always_comb begin
        accept    = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
        rd_acc    = accept & ~wb.i_wb_we;
        wr_acc    = accept & wb.i_wb_we;
        reg_sel   = wb.i_wb_adr[4:2];
        not_empty = (count_q != '0);
        full      = (count_q == FULL_CNT);
        pop       = rd_acc & (reg_sel == 3'd0) & not_empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push      = i_kbd_valid & cap_en_q & (~full | pop);
        drop      = i_kbd_valid & cap_en_q & full & ~pop;

        status_word           = '0;
        status_word[0]        = not_empty;
        status_word[1]        = full;
        status_word[2]        = ovf_q;
        status_word[8 +: CW]  = count_q;

        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        cap_en_d  = cap_en_q;
        irq_en_d  = irq_en_q;
        flush_d   = 1'b0;
        scratch_d = scratch_q;
        ack_d     = accept;
        rdt_d     = '0;
        irq_d     = irq_en_q & (not_empty | ovf_q);

        if (flush_q) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push) wptr_d = wptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end

        if (wr_acc) begin
            case (reg_sel)
                3'd1: if (wb.i_wb_dat[2]) ovf_d = 1'b0;
                3'd2: begin
                    cap_en_d = wb.i_wb_dat[0];
                    irq_en_d = wb.i_wb_dat[1];
                    flush_d  = wb.i_wb_dat[2];
                end
                3'd3: scratch_d = wb.i_wb_dat;
                default: ;
            endcase
        end
        // Drop after the clear so a same-cycle overflow survives the W1C.
        if (drop) ovf_d = 1'b1;

`ifdef KBD_TIMESTAMP_EN
        ts_d = ts_q;
        if (pop) ts_d = ts_mem_q[rptr_q];
`endif

        if (rd_acc) begin
            case (reg_sel)
                3'd0: if (not_empty) rdt_d = 32'(mem_q[rptr_q]);
                3'd1: rdt_d = status_word;
                3'd2: rdt_d = {30'd0, irq_en_q, cap_en_q};
                3'd3: rdt_d = scratch_q;
`ifdef KBD_TIMESTAMP_EN
                3'd4: rdt_d = ts_q;
`endif
                default: rdt_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cap_en_q  <= 1'b1;
            irq_en_q  <= 1'b0;
            flush_q   <= 1'b0;
            scratch_q <= '0;
            ack_q     <= 1'b0;
            rdt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            cap_en_q  <= cap_en_d;
            irq_en_q  <= irq_en_d;
            flush_q   <= flush_d;
            scratch_q <= scratch_d;
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !flush_q) mem_q[wptr_q] <= i_kbd_data;
    end

`ifdef KBD_TIMESTAMP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            ts_q     <= ts_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !flush_q) ts_mem_q[wptr_q] <= ts_cnt_q;
    end
`endif

    assign wb.o_wb_rdt = rdt_q;
    assign wb.o_wb_ack = ack_q;
    assign o_irq       = irq_q;
endmodule

// File: tb/tb_wb_kbd_fifo_periph.sv
// Scoreboard bench for wb_kbd_fifo_periph: queue-based reference model, directed and random traffic.
module tb_wb_kbd_fifo_periph;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] kbd_data = '0;
    logic              kbd_valid = 1'b0;
    logic              irq;

    wb_kbd_fifo_periph_if wb_bus ();

    wb_kbd_fifo_periph #(.DATA_W(DATA_W), .DEPTH(DEPTH), .clk_freq_hz(100_000_000)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_kbd_data  (kbd_data),
        .i_kbd_valid (kbd_valid),
        .wb          (wb_bus),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        kind_q[$];

    logic [DATA_W-1:0] m_fifo[$];
    bit          m_ovf = 1'b0;
    bit          m_cap = 1'b1;
    bit          m_irq_en = 1'b0;
    logic [31:0] m_scratch = '0;

    bit mon_en = 1'b0;
    bit rst_at_edge = 1'b0;

    always @(posedge clk) rst_at_edge <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n = m_fifo.size();
        return (32'(n) << 8) | (32'(m_ovf) << 2) | (32'(n == DEPTH) << 1) | 32'(n != 0);
    endfunction

    function automatic bit m_irq();
        return m_irq_en && (m_fifo.size() != 0 || m_ovf);
    endfunction

    function automatic logic [31:0] m_read(input int sel);
        case (sel)
            0: if (m_fifo.size() != 0) return 32'(m_fifo.pop_front()); else return 32'd0;
            1: return m_status();
            2: return {30'd0, m_irq_en, m_cap};
            3: return m_scratch;
            default: return 32'd0;
        endcase
    endfunction

    // One bus access and/or one keyboard strobe presented in the same clock cycle.
    task automatic cycle_op(input bit do_bus, input bit we, input logic [5:0] adr,
                            input logic [31:0] dat, input bit do_kbd, input logic [DATA_W-1:0] kd);
        bit flush;
        int sel;
        flush = 1'b0;
        sel = int'(adr[4:2]);
        @(negedge clk);
        if (do_bus) begin
            wb_bus.i_wb_cyc = 1'b1;
            wb_bus.i_wb_stb = 1'b1;
            wb_bus.i_wb_we  = we;
            wb_bus.i_wb_adr = adr;
            wb_bus.i_wb_dat = dat;
            wb_bus.i_wb_sel = 4'hf;
        end
        kbd_valid = do_kbd;
        kbd_data  = kd;
        @(posedge clk);
        if (do_bus) begin
            kind_q.push_back(!we);
            if (!we) exp_q.push_back(m_read(sel));
            else begin
                case (sel)
                    1: if (dat[2]) m_ovf = 1'b0;
                    2: begin m_cap = dat[0]; m_irq_en = dat[1]; flush = dat[2]; end
                    3: m_scratch = dat;
                    default: ;
                endcase
            end
        end
        if (do_kbd && m_cap) begin
            if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
            else m_fifo.push_back(kd);
        end
        @(negedge clk);
        kbd_valid = 1'b0;
        if (do_bus) begin
            check("ack_latency", 32'(wb_bus.o_wb_ack), 32'd1);
            wb_bus.i_wb_cyc = 1'b0;
            wb_bus.i_wb_stb = 1'b0;
            wb_bus.i_wb_we  = 1'b0;
        end
        if (flush) begin
            @(posedge clk);
            m_fifo.delete();
        end
    endtask

    task automatic rd(input logic [5:0] adr);
        cycle_op(1'b1, 1'b0, adr, 32'd0, 1'b0, '0);
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] dat);
        cycle_op(1'b1, 1'b1, adr, dat, 1'b0, '0);
    endtask

    task automatic kbd(input logic [DATA_W-1:0] kd);
        cycle_op(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, kd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_op(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, '0);
    endtask

    task automatic do_reset(input bit with_req);
        @(negedge clk);
        rst = 1'b1;
        if (with_req) begin
            wb_bus.i_wb_cyc = 1'b1;
            wb_bus.i_wb_stb = 1'b1;
            wb_bus.i_wb_we  = 1'b0;
            wb_bus.i_wb_adr = 6'h00;
        end
        @(posedge clk);
        m_fifo.delete();
        m_ovf = 1'b0;
        m_cap = 1'b1;
        m_irq_en = 1'b0;
        m_scratch = '0;
        @(negedge clk);
        rst = 1'b0;
        wb_bus.i_wb_cyc = 1'b0;
        wb_bus.i_wb_stb = 1'b0;
        mon_en = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every ack, tracks ack width and the registered irq.
    initial begin
        bit prev_ack;
        bit irq_exp;
        bit is_read;
        prev_ack = 1'b0;
        irq_exp  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_at_edge) begin
                    check("rst_ack", 32'(wb_bus.o_wb_ack), 32'd0);
                    check("rst_rdt", wb_bus.o_wb_rdt, 32'd0);
                    irq_exp = 1'b0;
                end
                check("irq", 32'(irq), 32'(irq_exp));
                if (wb_bus.o_wb_ack === 1'b1) begin
                    check("ack_single", 32'(prev_ack), 32'd0);
                    check("ack_outstanding", 32'(kind_q.size() != 0), 32'd1);
                    if (kind_q.size() != 0) begin
                        is_read = kind_q.pop_front();
                        if (is_read && exp_q.size() != 0) check("rdata", wb_bus.o_wb_rdt, exp_q.pop_front());
                    end
                end
                prev_ack = (wb_bus.o_wb_ack === 1'b1);
                irq_exp  = m_irq();
            end
        end
    end

    initial begin
        wb_bus.i_wb_adr = '0;
        wb_bus.i_wb_dat = '0;
        wb_bus.i_wb_sel = '0;
        wb_bus.i_wb_we  = 1'b0;
        wb_bus.i_wb_cyc = 1'b0;
        wb_bus.i_wb_stb = 1'b0;

        do_reset(1'b0);
        rd(6'h04); rd(6'h08); rd(6'h00);

        kbd(8'h1C); kbd(8'h32); kbd(8'h21);
        rd(6'h04);
        rd(6'h00); rd(6'h00); rd(6'h00);
        rd(6'h04);

        for (int i = 1; i <= 17; i++) kbd(8'(i));
        rd(6'h04);
        rd(6'h00);
        wr(6'h04, 32'h4);
        rd(6'h04);

        // Full FIFO: pop and push in the same cycle, then drain all 16.
        kbd(8'h55);
        rd(6'h04);
        cycle_op(1'b1, 1'b0, 6'h00, 32'd0, 1'b1, 8'hAA);
        rd(6'h04);
        for (int i = 0; i < DEPTH; i++) rd(6'h00);
        rd(6'h04);

        // Empty FIFO: pop is invalid and only the push lands.
        cycle_op(1'b1, 1'b0, 6'h00, 32'd0, 1'b1, 8'h77);
        rd(6'h00);

        wr(6'h08, 32'h3);
        kbd(8'h42);
        idle(3);
        rd(6'h00);
        idle(3);
        for (int i = 0; i < 5; i++) kbd(8'(8'h60 + i));
        wr(6'h08, 32'h7);
        rd(6'h04); rd(6'h08);

        // Overflow set and W1C in the same cycle; flush vs push; capture off.
        for (int i = 0; i < DEPTH; i++) kbd(8'(8'h80 + i));
        cycle_op(1'b1, 1'b1, 6'h04, 32'h4, 1'b1, 8'hEE);
        rd(6'h04);
        cycle_op(1'b1, 1'b1, 6'h08, 32'h5, 1'b1, 8'hEF);
        rd(6'h04);
        wr(6'h04, 32'h4);
        wr(6'h08, 32'h0);
        kbd(8'h11);
        rd(6'h04);
        wr(6'h08, 32'h1);
        wr(6'h00, 32'hFF);
        wr(6'h0C, 32'hDEADBEEF);
        rd(6'h0C);
        wr(6'h14, 32'h12345678);
        for (int a = 4; a < 8; a++) rd(6'(a << 2));

        for (int i = 0; i < 4; i++) kbd(8'(8'hC0 + i));
        do_reset(1'b1);
        rd(6'h04); rd(6'h08);

        for (int i = 0; i < 400; i++) begin
            bit          do_bus, we, do_k;
            logic [5:0]  adr;
            logic [31:0] dat;
            do_bus = ($urandom_range(0, 1) == 1);
            do_k   = ($urandom_range(0, 9) < 6);
            we     = ($urandom_range(0, 3) == 0);
            adr    = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 1) == 1) adr[4:2] = 3'($urandom_range(0, 1));
            dat    = $urandom;
            if (adr[4:2] == 3'd2) begin
                dat[0] = ($urandom_range(0, 3) != 0);
                dat[2] = ($urandom_range(0, 7) == 0);
            end
            cycle_op(do_bus, we, adr, dat, do_k, 8'($urandom));
        end
        rd(6'h04);

        idle(4);
        check("scoreboard_drained", 32'(exp_q.size() + kind_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1, "timeout");
    end
endmodule
